// File: rtl/y86_pkg.sv
// Y86 fetch/decode shared definitions.
// Status codes, NOP field values and bundle widths.
package y86_pkg;

  localparam int STAT_W  = 3;
  localparam int ICODE_W = 4;
  localparam int IFUN_W  = 4;
  localparam int REG_W   = 4;

  localparam logic [STAT_W-1:0] STAT_BUB = 3'd0;
  localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

  localparam logic [ICODE_W-1:0] ICODE_NOP = 4'h1;
  localparam logic [IFUN_W-1:0]  IFUN_NONE = 4'h0;
  localparam logic [REG_W-1:0]   RNONE     = 4'hF;

endpackage

// File: rtl/pipe_stage.sv
// One fetch/decode bundle register.
// Load, hold, or NOP-select with synchronous reset.
module pipe_stage
  import y86_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ld,
  input  logic               i_nop,
  input  logic [STAT_W-1:0]  i_status,
  input  logic [ICODE_W-1:0] i_icode,
  input  logic [IFUN_W-1:0]  i_ifun,
  input  logic [REG_W-1:0]   i_rA,
  input  logic [REG_W-1:0]   i_rB,
  input  logic [WORD_W-1:0]  i_valC,
  input  logic [WORD_W-1:0]  i_valP,
  output logic [STAT_W-1:0]  o_status,
  output logic [ICODE_W-1:0] o_icode,
  output logic [IFUN_W-1:0]  o_ifun,
  output logic [REG_W-1:0]   o_rA,
  output logic [REG_W-1:0]   o_rB,
  output logic [WORD_W-1:0]  o_valC,
  output logic [WORD_W-1:0]  o_valP
);

  logic [STAT_W-1:0]  r_status;
  logic [ICODE_W-1:0] r_icode;
  logic [IFUN_W-1:0]  r_ifun;
  logic [REG_W-1:0]   r_rA;
  logic [REG_W-1:0]   r_rB;
  logic [WORD_W-1:0]  r_valC;
  logic [WORD_W-1:0]  r_valP;

  // reset or enabled bubble loads NOP; enabled load takes input; else hold
  always_ff @(posedge i_clk) begin
    if (i_rst || (i_ld && i_nop)) begin
      r_status <= STAT_BUB;
      r_icode  <= ICODE_NOP;
      r_ifun   <= IFUN_NONE;
      r_rA     <= RNONE;
      r_rB     <= RNONE;
      r_valC   <= '0;
      r_valP   <= '0;
    end else if (i_ld) begin
      r_status <= i_status;
      r_icode  <= i_icode;
      r_ifun   <= i_ifun;
      r_rA     <= i_rA;
      r_rB     <= i_rB;
      r_valC   <= i_valC;
      r_valP   <= i_valP;
    end
  end

  assign o_status = r_status;
  assign o_icode  = r_icode;
  assign o_ifun   = r_ifun;
  assign o_rA     = r_rA;
  assign o_rB     = r_rB;
  assign o_valC   = r_valC;
  assign o_valP   = r_valP;

endmodule

// File: rtl/fd_pipe_reg.sv
// Fetch-to-decode pipeline register, DEPTH stages deep.
// Stall/bubble control with saturating event counters.
module fd_pipe_reg
  import y86_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               stall,
  input  logic               bubble,
  input  logic [STAT_W-1:0]  F_status,
  input  logic [ICODE_W-1:0] F_icode,
  input  logic [IFUN_W-1:0]  F_ifun,
  input  logic [REG_W-1:0]   F_rA,
  input  logic [REG_W-1:0]   F_rB,
  input  logic [WORD_W-1:0]  F_valC,
  input  logic [WORD_W-1:0]  F_valP,
  output logic [STAT_W-1:0]  d_status,
  output logic [ICODE_W-1:0] d_icode,
  output logic [IFUN_W-1:0]  d_ifun,
  output logic [REG_W-1:0]   d_rA,
  output logic [REG_W-1:0]   d_rB,
  output logic [WORD_W-1:0]  d_valC,
  output logic [WORD_W-1:0]  d_valP,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic               ctrl_err
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("fd_pipe_reg: DEPTH must be in 1..4");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STAT_W-1:0]  w_status [DEPTH+1];
  logic [ICODE_W-1:0] w_icode  [DEPTH+1];
  logic [IFUN_W-1:0]  w_ifun   [DEPTH+1];
  logic [REG_W-1:0]   w_rA     [DEPTH+1];
  logic [REG_W-1:0]   w_rB     [DEPTH+1];
  logic [WORD_W-1:0]  w_valC   [DEPTH+1];
  logic [WORD_W-1:0]  w_valP   [DEPTH+1];

  logic w_ld;

  assign w_ld = ~stall;

  assign w_status[0] = F_status;
  assign w_icode[0]  = F_icode;
  assign w_ifun[0]   = F_ifun;
  assign w_rA[0]     = F_rA;
  assign w_rB[0]     = F_rB;
  assign w_valC[0]   = F_valC;
  assign w_valP[0]   = F_valP;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage #(
      .WORD_W(WORD_W)
    ) u_stage (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_ld    (w_ld),
      .i_nop   ((k == 0) ? bubble : 1'b0),
      .i_status(w_status[k]),
      .i_icode (w_icode[k]),
      .i_ifun  (w_ifun[k]),
      .i_rA    (w_rA[k]),
      .i_rB    (w_rB[k]),
      .i_valC  (w_valC[k]),
      .i_valP  (w_valP[k]),
      .o_status(w_status[k+1]),
      .o_icode (w_icode[k+1]),
      .o_ifun  (w_ifun[k+1]),
      .o_rA    (w_rA[k+1]),
      .o_rB    (w_rB[k+1]),
      .o_valC  (w_valC[k+1]),
      .o_valP  (w_valP[k+1])
    );
  end

  assign d_status = w_status[DEPTH];
  assign d_icode  = w_icode[DEPTH];
  assign d_ifun   = w_ifun[DEPTH];
  assign d_rA     = w_rA[DEPTH];
  assign d_rB     = w_rB[DEPTH];
  assign d_valC   = w_valC[DEPTH];
  assign d_valP   = w_valP[DEPTH];

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             r_ctrl_err;

  // saturating stall/bubble counters and sticky conflict flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_ctrl_err   <= 1'b0;
    end else begin
      if (stall && r_stall_cnt != CNT_MAX)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (bubble && !stall && r_bubble_cnt != CNT_MAX)
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (stall && bubble)
        r_ctrl_err <= 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign ctrl_err   = r_ctrl_err;

endmodule
